// File: rtl/pathfinder_ci_bridge.sv
// Pathfinder custom-instruction bridge: decodes Nios II CI opcodes, arbitrates
// the edge cache between the engine, CI edge ops and an Avalon slave, and
// tracks engine launch/done status with a level interrupt.
module pathfinder_ci_bridge #(
  parameter int unsigned INDEX_WIDTH = 10,
  parameter int unsigned VALUE_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  // Nios II custom instruction
  input  logic                     clock_enable,
  input  logic                     start,
  input  logic [7:0]               select_n,
  input  logic [31:0]              dataa,
  input  logic [31:0]              datab,
  output logic [31:0]              result,
  output logic                     ready,
  // Avalon slave into the edge cache
  input  logic [2*INDEX_WIDTH-1:0] slave_address,
  input  logic                     slave_read,
  input  logic                     slave_write,
  input  logic [31:0]              slave_writedata,
  output logic [31:0]              slave_readdata,
  output logic                     slave_waitrequest,
  output logic                     irq,
  // Edge cache
  output logic                     ec_read,
  output logic                     ec_write,
  output logic [INDEX_WIDTH-1:0]   ec_from,
  output logic [INDEX_WIDTH-1:0]   ec_to,
  output logic [VALUE_WIDTH-1:0]   ec_wdata,
  input  logic [VALUE_WIDTH-1:0]   ec_rdata,
  input  logic                     ec_ready,
  // Path engine
  output logic                     eng_start,
  output logic [INDEX_WIDTH-1:0]   eng_source,
  output logic [INDEX_WIDTH-1:0]   eng_dest,
  output logic [INDEX_WIDTH:0]     eng_nodes,
  input  logic                     eng_done,
  input  logic [VALUE_WIDTH-1:0]   eng_distance,
  input  logic                     eng_ec_read,
  input  logic [INDEX_WIDTH-1:0]   eng_ec_from,
  input  logic [INDEX_WIDTH-1:0]   eng_ec_to
);

  localparam logic [7:0]  OpWriteEdge = 8'd0;
  localparam logic [7:0]  OpReadEdge  = 8'd1;
  localparam logic [7:0]  OpLaunch    = 8'd2;
  localparam logic [7:0]  OpStatus    = 8'd3;
  localparam logic [7:0]  OpDistance  = 8'd4;
  localparam logic [7:0]  OpClearIrq  = 8'd5;
  localparam logic [31:0] ResIdle     = 32'hDEAD_BEEF;

  typedef enum logic [0:0] {StIdle, StExec} state_t;

  state_t state_q, state_d;

  // CI operands captured at start so the host may change them mid-op
  logic [7:0]             op_q;
  logic [INDEX_WIDTH-1:0] from_q, to_q;
  logic [VALUE_WIDTH-1:0] wdata_q;
  logic [INDEX_WIDTH:0]   nodes_q;

  logic                   busy_q, done_valid_q, irq_pending_q;
  logic [VALUE_WIDTH-1:0] distance_q;
  logic [INDEX_WIDTH-1:0] eng_source_q, eng_dest_q;
  logic [INDEX_WIDTH:0]   eng_nodes_q;
  logic                   eng_start_q;

  logic is_edge_op, ci_owns, slave_req, slave_owns;
  logic complete, launch, clear_irq, engine_finish;

  logic unused_dataa;
  assign unused_dataa = ^{dataa[31:16+INDEX_WIDTH], dataa[15:INDEX_WIDTH]};

  // Ownership arbitration and CI completion qualification
  always_comb begin
    is_edge_op    = (op_q == OpWriteEdge) || (op_q == OpReadEdge);
    ci_owns       = (state_q == StExec) && is_edge_op && !busy_q;
    slave_req     = slave_read || slave_write;
    slave_owns    = !busy_q && !ci_owns && slave_req;
    // Edge ops stall until they own the cache and it answers; others finish at once
    complete      = (state_q == StExec) && clock_enable && (!is_edge_op || (ci_owns && ec_ready));
    launch        = complete && (op_q == OpLaunch) && !busy_q;
    clear_irq     = complete && (op_q == OpClearIrq);
    engine_finish = eng_done && busy_q;
  end

  // CI FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // CI FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StExec;
      StExec: if (complete) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // CI FSM outputs: ready pulse and result mux
  always_comb begin
    ready  = complete;
    result = ResIdle;
    if (complete) begin
      case (op_q)
        OpWriteEdge: result = 32'h0000_BEEF;
        OpReadEdge:  result = 32'(ec_rdata);
        OpLaunch:    result = busy_q ? 32'hFFFF_FFFF : 32'h0;
        OpStatus:    result = {29'b0, irq_pending_q, done_valid_q, busy_q};
        OpDistance:  result = 32'(distance_q);
        OpClearIrq:  result = 32'h0;
        default:     result = ResIdle;
      endcase
    end
  end

  // Operand capture, status flags, distance and engine launch latches
  always_ff @(posedge clock) begin
    if (reset) begin
      op_q          <= 8'h0;
      from_q        <= '0;
      to_q          <= '0;
      wdata_q       <= '0;
      nodes_q       <= '0;
      busy_q        <= 1'b0;
      done_valid_q  <= 1'b0;
      irq_pending_q <= 1'b0;
      distance_q    <= '0;
      eng_source_q  <= '0;
      eng_dest_q    <= '0;
      eng_nodes_q   <= '0;
      eng_start_q   <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      if ((state_q == StIdle) && start) begin
        op_q    <= select_n;
        from_q  <= dataa[INDEX_WIDTH-1:0];
        to_q    <= dataa[16+INDEX_WIDTH-1:16];
        wdata_q <= datab[VALUE_WIDTH-1:0];
        nodes_q <= datab[INDEX_WIDTH:0];
      end
      if (launch) begin
        eng_source_q  <= from_q;
        eng_dest_q    <= to_q;
        eng_nodes_q   <= nodes_q;
        eng_start_q   <= 1'b1;
        busy_q        <= 1'b1;
        done_valid_q  <= 1'b0;
        irq_pending_q <= 1'b0;
      end
      if (clear_irq) irq_pending_q <= 1'b0;
      // Engine completion overrides a same-cycle irq clear
      if (engine_finish) begin
        distance_q    <= eng_distance;
        busy_q        <= 1'b0;
        done_valid_q  <= 1'b1;
        irq_pending_q <= 1'b1;
      end
    end
  end

  // Edge cache mux: engine, then CI edge op, then Avalon slave
  always_comb begin
    ec_read  = 1'b0;
    ec_write = 1'b0;
    ec_from  = '0;
    ec_to    = '0;
    ec_wdata = '0;
    if (busy_q) begin
      ec_read = eng_ec_read;
      ec_from = eng_ec_from;
      ec_to   = eng_ec_to;
    end else if (ci_owns) begin
      ec_read  = (op_q == OpReadEdge);
      ec_write = (op_q == OpWriteEdge);
      ec_from  = from_q;
      ec_to    = to_q;
      ec_wdata = wdata_q;
    end else if (slave_owns) begin
      ec_write = slave_write;
      ec_read  = slave_read && !slave_write;
      ec_from  = slave_address[INDEX_WIDTH-1:0];
      ec_to    = slave_address[2*INDEX_WIDTH-1:INDEX_WIDTH];
      ec_wdata = slave_writedata[VALUE_WIDTH-1:0];
    end
  end

  // Avalon handshake and read data
  always_comb begin
    slave_waitrequest = slave_req && !(slave_owns && ec_ready);
    slave_readdata    = slave_owns ? 32'(ec_rdata) : ResIdle;
  end

  assign irq        = irq_pending_q;
  assign eng_start  = eng_start_q;
  assign eng_source = eng_source_q;
  assign eng_dest   = eng_dest_q;
  assign eng_nodes  = eng_nodes_q;

endmodule

// File: doc/pathfinder_ci_bridge.md
PATHFINDER_CI_BRIDGE -- requirements
Module: pathfinder_ci_bridge

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 10, meaning node index width (max nodes 2**INDEX_WIDTH).
REQ-002 SHALL have parameter VALUE_WIDTH, default 32, meaning edge weight and distance width (<=32).
REQ-003 SHALL have the following ports, one per line: name, direction, width, meaning.
- clock  in  1  clock; all state on rising edge.
- reset  in  1  reset, synchronous, active-high.
- clock_enable  in  1  Nios II CI clk_en; completion only when high.
- start  in  1  CI start strobe.
- select_n  in  8  CI opcode.
- dataa  in  32  CI operand A; [INDEX_WIDTH-1:0] = from/source, [16+INDEX_WIDTH-1:16] = to/dest.
- datab  in  32  CI operand B; weight (op 0) or node count (op 2).
- result  out  32  CI result.
- ready  out  1  CI done, one-cycle pulse.
- slave_address  in  2*INDEX_WIDTH  Avalon: low half = from, high half = to.
- slave_read  in  1  Avalon read.
- slave_write  in  1  Avalon write.
- slave_writedata  in  32  Avalon write data.
- slave_readdata  out  32  Avalon read data.
- slave_waitrequest  out  1  Avalon stall.
- irq  out  1  compute-done interrupt, level.
- ec_read  out  1  edge cache read request.
- ec_write  out  1  edge cache write request.
- ec_from  out  INDEX_WIDTH  edge cache from node.
- ec_to  out  INDEX_WIDTH  edge cache to node.
- ec_wdata  out  VALUE_WIDTH  edge cache write data.
- ec_rdata  in  VALUE_WIDTH  edge cache read data.
- ec_ready  in  1  edge cache access complete.
- eng_start  out  1  engine launch, one-cycle pulse.
- eng_source  out  INDEX_WIDTH  latched source node.
- eng_dest  out  INDEX_WIDTH  latched destination node.
- eng_nodes  out  INDEX_WIDTH+1  latched node count.
- eng_done  in  1  engine finished, one-cycle pulse.
- eng_distance  in  VALUE_WIDTH  engine shortest distance, valid with eng_done.
- eng_ec_read  in  1  engine edge cache read request.
- eng_ec_from  in  INDEX_WIDTH  engine from node.
- eng_ec_to  in  INDEX_WIDTH  engine to node.

Function
REQ-004 SHALL implement CI FSM states IDLE, EXEC; IDLE->EXEC on start; EXEC->IDLE in the completion cycle; ready=1 only in completion cycle, which requires clock_enable=1, else EXEC holds.
REQ-005 SHALL hold status flags busy, done_valid, irq_pending and a VALUE_WIDTH distance register; irq = irq_pending.
REQ-006 Op 0 (write edge): SHALL drive ec_write with dataa nodes and datab[VALUE_WIDTH-1:0]; complete when ec_ready; result 0x0000BEEF.
REQ-007 Op 1 (read edge): SHALL drive ec_read; complete when ec_ready; result = ec_rdata zero-extended.
REQ-008 Ops 0/1 while busy=1: SHALL stall in EXEC with no ec request until busy clears.
REQ-009 Op 2 (launch): if busy=0, SHALL latch eng_source/eng_dest/eng_nodes, pulse eng_start, set busy, clear done_valid and irq_pending, complete same EXEC cycle, result 0; if busy=1, SHALL complete with result 0xFFFFFFFF and no side effect.
REQ-010 Op 3 (status): SHALL complete first EXEC cycle, result = {29'b0, irq_pending, done_valid, busy}.
REQ-011 Op 4 (read distance): SHALL complete first EXEC cycle, result = distance register zero-extended.
REQ-012 Op 5 (clear irq): SHALL clear irq_pending, result 0; eng_done in same cycle SHALL win (irq_pending=1).
REQ-013 Other opcodes: SHALL complete first EXEC cycle, result 0xDEADBEEF.
REQ-014 On eng_done while busy: SHALL store eng_distance, clear busy, set done_valid and irq_pending; eng_done while busy=0 SHALL be ignored.
REQ-015 Edge cache ownership priority: engine (busy=1) > CI op 0/1 in EXEC > Avalon slave; non-owners SHALL see no ec request.
REQ-016 Avalon: slave_waitrequest = (slave_read|slave_write) && !(slave owns cache && ec_ready); slave_readdata = ec_rdata zero-extended when owner, else 0xDEADBEEF.
REQ-017 result SHALL be 0xDEADBEEF and ec outputs 0 when no completion/ownership applies.

Reset
REQ-018 reset SHALL force IDLE, busy=done_valid=irq_pending=0, distance=0, eng_* latches 0, irq=0, ready=0, eng_start=0; an in-flight CI op SHALL be abandoned without ready.

Verification
REQ-019 Op 0 dataa=0x0003_0002, datab=7, ec_ready after 2 cycles -> ec_write from=2,to=3,wdata=7; ready one cycle, result 0x0000BEEF.
REQ-020 Op 2 dataa=0x0005_0000, datab=6 -> eng_start pulse, source=0,dest=5,nodes=6, result 0; repeat op 2 -> result 0xFFFFFFFF, no eng_start.
REQ-021 eng_done with eng_distance=42 -> irq=1; op 3 result 0x6; op 4 result 42; op 5 -> irq=0, op 3 result 0x2.
REQ-022 Slave write during busy=1 -> slave_waitrequest high, no ec_write until eng_done; then completes on ec_ready.
REQ-023 Op 1 with clock_enable=0 while ec_ready=1 -> no ready; clock_enable=1 -> ready with ec_rdata; reset mid-EXEC -> no ready, all flags 0.
